// File: rtl/hist2d_accumulator_if.sv
// Stream bundle between the hist2d accumulator and its neighbours: the
// (i, q) coordinate input stream and the dump output stream.
interface hist2d_accumulator_if #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16
);
  logic               coord_valid;
  logic               coord_ready;
  logic [COORD_W-1:0] i_coord;
  logic [COORD_W-1:0] q_coord;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_i;
  logic [COORD_W-1:0] out_q;
  logic [COUNT_W-1:0] out_count;
  logic               out_last;

  modport master (
    output coord_valid, i_coord, q_coord, out_ready,
    input  coord_ready, out_valid, out_i, out_q, out_count, out_last
  );

  modport slave (
    input  coord_valid, i_coord, q_coord, out_ready,
    output coord_ready, out_valid, out_i, out_q, out_count, out_last
  );
endinterface

// File: rtl/hist2d_accumulator.sv
// 2D histogram accumulator: bins (i, q) pairs into a RAM addressed {i,q},
// counts out-of-range points separately, and streams the 63x63 histogram
// out in raster order on request, optionally clearing it afterwards.
module hist2d_accumulator #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16,
  parameter int TOTAL_W = 32
) (
  input  logic                   clk100,
  input  logic                   rst_n,
  hist2d_accumulator_if.slave    bus,
  input  logic                   dump_req,
  input  logic                   clear_after_dump,
  output logic [COUNT_W-1:0]     oor_count,
  output logic [TOTAL_W-1:0]     total_count,
  output logic                   busy
);

  localparam int AW    = 2 * COORD_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [COORD_W-1:0] BIN_OOR  = '1;
  localparam logic [COORD_W-1:0] BIN_LAST = {{(COORD_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_UPDATE,
    S_DUMP_RD,
    S_DUMP_OUT
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               r_state;
  logic [AW-1:0]        r_clr_addr;
  logic [AW-1:0]        r_upd_addr;
  logic [COORD_W-1:0]   r_di;
  logic [COORD_W-1:0]   r_dq;
  logic                 r_pending;
  logic                 r_clr_latch;
  logic                 r_coord_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [COUNT_W-1:0]   r_oor;
  logic [TOTAL_W-1:0]   r_total;
  logic [COUNT_W-1:0]   r_rdata;
  logic [COUNT_W-1:0]   r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_in_oor;
  logic                 w_last_bin;
  logic                 w_dump_req_acc;
  logic [AW-1:0]        w_raddr;
  logic                 w_we;
  logic [AW-1:0]        w_waddr;
  logic [COUNT_W-1:0]   w_wdata;

  assign w_accept       = r_coord_ready && bus.coord_valid;
  assign w_in_oor       = (bus.i_coord == BIN_OOR) || (bus.q_coord == BIN_OOR);
  assign w_last_bin     = (r_di == BIN_LAST) && (r_dq == BIN_LAST);
  // A second request while one is already pending is folded into it, so the
  // latched clear flag belongs to the request that armed the dump.
  assign w_dump_req_acc = dump_req && !r_pending &&
                          ((r_state == S_IDLE) || (r_state == S_UPDATE));

  // RAM port steering: reads follow the incoming pair in IDLE, otherwise the
  // dump address (held through DUMP_OUT so the read data stays stable).
  always_comb begin
    w_raddr = {r_di, r_dq};
    w_we    = 1'b0;
    w_waddr = r_upd_addr;
    w_wdata = sat_inc(r_rdata);
    if (r_state == S_IDLE) begin
      w_raddr = {bus.i_coord, bus.q_coord};
    end
    if (r_state == S_CLEAR && r_busy) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end else if (r_state == S_UPDATE) begin
      w_we = 1'b1;
    end
  end

  // Histogram RAM: single write port, registered read.
  always_ff @(posedge clk100) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rdata <= r_mem[w_raddr];
  end

  // Control FSM: clear sweep, accumulate/update, raster dump.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_CLEAR;
      r_clr_addr    <= '0;
      r_upd_addr    <= '0;
      r_di          <= '0;
      r_dq          <= '0;
      r_pending     <= 1'b0;
      r_clr_latch   <= 1'b0;
      r_coord_ready <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_oor         <= '0;
      r_total       <= '0;
    end else begin
      if (w_dump_req_acc) begin
        r_pending   <= 1'b1;
        r_clr_latch <= clear_after_dump;
      end
      case (r_state)
        S_CLEAR: begin
          // First cycle out of reset only raises busy; the sweep follows.
          if (!r_busy) begin
            r_busy <= 1'b1;
          end else if (&r_clr_addr) begin
            r_clr_addr    <= '0;
            r_busy        <= 1'b0;
            r_coord_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        S_IDLE: begin
          if (r_pending) begin
            r_pending     <= 1'b0;
            r_busy        <= 1'b1;
            r_coord_ready <= 1'b0;
            r_di          <= '0;
            r_dq          <= '0;
            r_state       <= S_DUMP_RD;
          end else if (w_accept && !w_in_oor) begin
            r_total       <= r_total + 1'b1;
            r_upd_addr    <= {bus.i_coord, bus.q_coord};
            r_coord_ready <= 1'b0;
            r_state       <= S_UPDATE;
          end else begin
            if (w_accept) begin
              r_total <= r_total + 1'b1;
              r_oor   <= sat_inc(r_oor);
            end
            r_coord_ready <= !w_dump_req_acc;
          end
        end
        S_UPDATE: begin
          r_coord_ready <= !(r_pending || w_dump_req_acc);
          r_state       <= S_IDLE;
        end
        S_DUMP_RD: begin
          r_out_valid <= 1'b1;
          r_state     <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_bin) begin
              r_di <= '0;
              r_dq <= '0;
              if (r_clr_latch) begin
                r_oor      <= '0;
                r_total    <= '0;
                r_clr_addr <= '0;
                r_state    <= S_CLEAR;
              end else begin
                r_busy        <= 1'b0;
                r_coord_ready <= 1'b1;
                r_state       <= S_IDLE;
              end
            end else begin
              if (r_dq == BIN_LAST) begin
                r_dq <= '0;
                r_di <= r_di + 1'b1;
              end else begin
                r_dq <= r_dq + 1'b1;
              end
              r_state <= S_DUMP_RD;
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign bus.coord_ready = r_coord_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_i       = r_di;
  assign bus.out_q       = r_dq;
  assign bus.out_count   = r_out_valid ? r_rdata : '0;
  assign bus.out_last    = r_out_valid && w_last_bin;
  assign oor_count       = r_oor;
  assign total_count     = r_total;
  assign busy            = r_busy;

endmodule
